// File: rtl/rc4_ksa.sv
// RC4 key-scheduling controller driving a 256x8 sarr state array: identity fill, then KSA permutation.
// Optional abort input enabled by defining RC4_KSA_ABORT_EN.
module rc4_ksa #(
    parameter int unsigned KEY_LEN = 3
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   start_i,
    input  logic [8*KEY_LEN-1:0]   key_i,
`ifdef RC4_KSA_ABORT_EN
    input  logic                   abort_i,
`endif
    output logic                   busy_o,
    output logic                   done_o,
    output logic [7:0]             waddr_o,
    output logic [7:0]             wdata_o,
    output logic                   wenable_o,
    output logic [7:0]             raddr_o,
    output logic                   renable_o,
    output logic                   swap_o,
    input  logic [7:0]             rdata_i
);

    localparam int unsigned KEY_W = 8 * KEY_LEN;
    localparam int unsigned KW    = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(KEY_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        READ_I,
        CALC_J,
        SWAP,
        DONE
    } state_t;

    state_t           state;
    logic [7:0]       i;
    logic [7:0]       j;
    logic [KW-1:0]    k;
    logic [KEY_W-1:0] key_q;

    logic [KEY_W-1:0] key_sh;
    logic [7:0]       key_byte;
    logic [7:0]       j_sum;

    // Key byte k sits at the top of the register once shifted left by k bytes (byte 0 is MSB-first).
    always_comb begin
        key_sh   = key_q << {k, 3'b000};
        key_byte = key_sh[KEY_W-1 -: 8];
        j_sum    = j + rdata_i + key_byte;
    end

    // Outputs are registered and loaded with the decode of the state being entered,
    // so they behave as a Moore decode of the state register and counters.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            i         <= 8'd0;
            j         <= 8'd0;
            k         <= '0;
            key_q     <= '0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            waddr_o   <= 8'd0;
            wdata_o   <= 8'd0;
            wenable_o <= 1'b0;
            raddr_o   <= 8'd0;
            renable_o <= 1'b0;
            swap_o    <= 1'b0;
        end else begin
            done_o    <= 1'b0;
            waddr_o   <= 8'd0;
            wdata_o   <= 8'd0;
            wenable_o <= 1'b0;
            raddr_o   <= 8'd0;
            renable_o <= 1'b0;
            swap_o    <= 1'b0;

            case (state)
                IDLE: begin
                    if (start_i) begin
                        key_q     <= key_i;
                        i         <= 8'd0;
                        j         <= 8'd0;
                        k         <= '0;
                        state     <= INIT;
                        busy_o    <= 1'b1;
                        wenable_o <= 1'b1;
                    end
                end
                INIT: begin
                    if (i == 8'd255) begin
                        i         <= 8'd0;
                        j         <= 8'd0;
                        k         <= '0;
                        state     <= READ_I;
                        renable_o <= 1'b1;
                    end else begin
                        i         <= i + 8'd1;
                        wenable_o <= 1'b1;
                        waddr_o   <= i + 8'd1;
                        wdata_o   <= i + 8'd1;
                    end
                end
                READ_I: begin
                    state <= CALC_J;
                end
                CALC_J: begin
                    j       <= j_sum;
                    state   <= SWAP;
                    swap_o  <= 1'b1;
                    raddr_o <= i;
                    waddr_o <= j_sum;
                end
                SWAP: begin
                    k <= (k == K_LAST) ? '0 : k + KW'(1);
                    if (i == 8'd255) begin
                        state  <= DONE;
                        done_o <= 1'b1;
                    end else begin
                        i         <= i + 8'd1;
                        state     <= READ_I;
                        renable_o <= 1'b1;
                        raddr_o   <= i + 8'd1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase

`ifdef RC4_KSA_ABORT_EN
            // Abort overrides whatever the case statement scheduled.
            if (abort_i && (state != IDLE)) begin
                state     <= IDLE;
                busy_o    <= 1'b0;
                done_o    <= 1'b0;
                waddr_o   <= 8'd0;
                wdata_o   <= 8'd0;
                wenable_o <= 1'b0;
                raddr_o   <= 8'd0;
                renable_o <= 1'b0;
                swap_o    <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_rc4_ksa.sv
// Self-checking bench for rc4_ksa: sarr behavioural models plus a software RC4 KSA reference.
module tb_rc4_ksa;

    logic clk = 1'b0;
    logic n_rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // KEY_LEN=3 instance
    logic        start3 = 1'b0;
    logic [23:0] key3 = '0;
    logic        abort3 = 1'b0;
    logic        busy3, done3, wen3, ren3, swap3;
    logic [7:0]  waddr3, wdata3, raddr3, rdata3;

    // KEY_LEN=1 instance
    logic        start1 = 1'b0;
    logic [7:0]  key1 = '0;
    logic        abort1 = 1'b0;
    logic        busy1, done1, wen1, ren1, swap1;
    logic [7:0]  waddr1, wdata1, raddr1, rdata1;

    rc4_ksa #(.KEY_LEN(3)) dut3 (
        .clk(clk), .n_rst(n_rst), .start_i(start3), .key_i(key3),
`ifdef RC4_KSA_ABORT_EN
        .abort_i(abort3),
`endif
        .busy_o(busy3), .done_o(done3), .waddr_o(waddr3), .wdata_o(wdata3),
        .wenable_o(wen3), .raddr_o(raddr3), .renable_o(ren3), .swap_o(swap3),
        .rdata_i(rdata3)
    );

    rc4_ksa #(.KEY_LEN(1)) dut1 (
        .clk(clk), .n_rst(n_rst), .start_i(start1), .key_i(key1),
`ifdef RC4_KSA_ABORT_EN
        .abort_i(abort1),
`endif
        .busy_o(busy1), .done_o(done1), .waddr_o(waddr1), .wdata_o(wdata1),
        .wenable_o(wen1), .raddr_o(raddr1), .renable_o(ren1), .swap_o(swap1),
        .rdata_i(rdata1)
    );

    // sarr models and activity monitors
    logic [7:0] mem3 [256];
    logic [7:0] mem1 [256];
    logic [7:0] swj3 [256];
    logic [7:0] swj1 [256];
    int act3 = 0, act1 = 0, wr3 = 0, initerr3 = 0, done_cnt3 = 0, swcnt3 = 0, excl3 = 0;
    int done_cnt1 = 0, swcnt1 = 0, excl1 = 0;
    logic       pwe3 = 1'b0;
    logic [7:0] paddr3 = '0;

    always @(posedge clk) begin
        if (wen3) mem3[waddr3] <= wdata3;
        if (swap3) begin
            mem3[raddr3] <= mem3[waddr3];
            mem3[waddr3] <= mem3[raddr3];
            swj3[raddr3] <= waddr3;
            swcnt3 <= swcnt3 + 1;
        end
        if (ren3) rdata3 <= mem3[raddr3];
        if (wen3 || ren3 || swap3) act3 <= act3 + 1;
        if (wen3) wr3 <= wr3 + 1;
        if (wen3 && ((waddr3 != wdata3) ||
                     ((waddr3 != 8'd0) && !(pwe3 && (paddr3 == waddr3 - 8'd1)))))
            initerr3 <= initerr3 + 1;
        pwe3 <= wen3;
        paddr3 <= waddr3;
        if (done3) done_cnt3 <= done_cnt3 + 1;
        if ($countones({wen3, ren3, swap3}) > 1) excl3 <= excl3 + 1;
    end

    always @(posedge clk) begin
        if (wen1) mem1[waddr1] <= wdata1;
        if (swap1) begin
            mem1[raddr1] <= mem1[waddr1];
            mem1[waddr1] <= mem1[raddr1];
            swj1[raddr1] <= waddr1;
            swcnt1 <= swcnt1 + 1;
        end
        if (ren1) rdata1 <= mem1[raddr1];
        if (wen1 || ren1 || swap1) act1 <= act1 + 1;
        if (done1) done_cnt1 <= done_cnt1 + 1;
        if ($countones({wen1, ren1, swap1}) > 1) excl1 <= excl1 + 1;
    end

    // Software RC4 KSA reference
    int ref_s [256];
    int ref_j [256];

    task automatic compute_ref(input logic [255:0] kb, input int len);
        int jj, t, kbyte;
        logic [255:0] kv;
        kv = kb;
        for (int n = 0; n < 256; n++) ref_s[n] = n;
        jj = 0;
        for (int n = 0; n < 256; n++) begin
            kbyte = int'(kv[8*(len-1-(n % len)) +: 8]);
            jj = (jj + ref_s[n] + kbyte) % 256;
            ref_j[n] = jj;
            t = ref_s[n];
            ref_s[n] = ref_s[jj];
            ref_s[jj] = t;
        end
    endtask

    task automatic do_run3(input logic [23:0] key, output int lat);
        @(negedge clk); start3 = 1'b1; key3 = key;
        @(negedge clk); start3 = 1'b0; key3 = ~key;
        lat = 1;
        while (done3 !== 1'b1 && lat < 2000) begin @(negedge clk); lat++; end
        @(negedge clk);
    endtask

    task automatic do_run1(input logic [7:0] key, output int lat);
        @(negedge clk); start1 = 1'b1; key1 = key;
        @(negedge clk); start1 = 1'b0; key1 = ~key;
        lat = 1;
        while (done1 !== 1'b1 && lat < 2000) begin @(negedge clk); lat++; end
        @(negedge clk);
    endtask

    task automatic test_reset();
        int a0;
        #3 n_rst = 1'b0;
        #1;
        checks++;
        if ({busy3, done3, waddr3, wdata3, wen3, raddr3, ren3, swap3} !== 27'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %h want 0", {busy3, done3, waddr3, wdata3, wen3, raddr3, ren3, swap3});
        end
        @(negedge clk); n_rst = 1'b1;
        a0 = act3;
        repeat (10) @(negedge clk);
        checks++;
        if (act3 - a0 !== 0 || busy3 !== 1'b0) begin
            failures++;
            $display("FAIL idle_quiet: activity=%0d busy=%b want 0 0", act3 - a0, busy3);
        end
    endtask

    task automatic test_identity_key();
        int lat, w0, e0, s0, bad, badj;
        w0 = wr3; e0 = initerr3; s0 = swcnt3;
        compute_ref(256'(24'h010203), 3);
        do_run3(24'h010203, lat);
        checks++;
        if (lat !== 1025) begin failures++; $display("FAIL id_latency: got %0d want 1025", lat); end
        checks++;
        if (wr3 - w0 !== 256 || initerr3 - e0 !== 0) begin
            failures++; $display("FAIL id_init: writes=%0d errs=%0d want 256 0", wr3 - w0, initerr3 - e0);
        end
        checks++;
        if (swj3[0] !== 8'd1 || swj3[1] !== 8'd3) begin
            failures++; $display("FAIL id_first_swaps: j0=%0d j1=%0d want 1 3", swj3[0], swj3[1]);
        end
        bad = 0; badj = 0;
        for (int n = 0; n < 256; n++) begin
            if (int'(mem3[n]) !== ref_s[n]) bad++;
            if (int'(swj3[n]) !== ref_j[n]) badj++;
        end
        checks++;
        if (bad !== 0 || badj !== 0 || swcnt3 - s0 !== 256) begin
            failures++; $display("FAIL id_array: bad_s=%0d bad_j=%0d swaps=%0d want 0 0 256", bad, badj, swcnt3 - s0);
        end
    endtask

    task automatic test_zero_key();
        int lat, bad;
        compute_ref(256'(0), 3);
        do_run3(24'h000000, lat);
        checks++;
        if (swj3[0] !== 8'd0 || swj3[1] !== 8'd1 || swj3[2] !== 8'd3) begin
            failures++; $display("FAIL zero_swaps: j=%0d,%0d,%0d want 0,1,3", swj3[0], swj3[1], swj3[2]);
        end
        bad = 0;
        for (int n = 0; n < 256; n++) if (int'(mem3[n]) !== ref_s[n]) bad++;
        checks++;
        if (bad !== 0 || lat !== 1025) begin
            failures++; $display("FAIL zero_array: bad=%0d lat=%0d want 0 1025", bad, lat);
        end
    endtask

    task automatic test_key_len1();
        int lat, bad, s0;
        s0 = swcnt1;
        compute_ref(256'(8'hFF), 1);
        do_run1(8'hFF, lat);
        checks++;
        if (swj1[0] !== 8'hFF) begin failures++; $display("FAIL len1_wrap: j0=%h want ff", swj1[0]); end
        bad = 0;
        for (int n = 0; n < 256; n++) if (int'(mem1[n]) !== ref_s[n]) bad++;
        checks++;
        if (bad !== 0 || lat !== 1025 || swcnt1 - s0 !== 256 || excl1 !== 0) begin
            failures++; $display("FAIL len1_array: bad=%0d lat=%0d swaps=%0d excl=%0d want 0 1025 256 0",
                                 bad, lat, swcnt1 - s0, excl1);
        end
    endtask

    task automatic test_random();
        int lat, bad;
        logic [23:0] k3;
        logic [7:0]  k1;
        for (int r = 0; r < 3; r++) begin
            k3 = 24'($urandom);
            compute_ref(256'(k3), 3);
            do_run3(k3, lat);
            bad = 0;
            for (int n = 0; n < 256; n++) if (int'(mem3[n]) !== ref_s[n]) bad++;
            checks++;
            if (bad !== 0 || lat !== 1025) begin
                failures++; $display("FAIL rand3 key=%h: bad=%0d lat=%0d want 0 1025", k3, bad, lat);
            end
        end
        for (int r = 0; r < 2; r++) begin
            k1 = 8'($urandom);
            compute_ref(256'(k1), 1);
            do_run1(k1, lat);
            bad = 0;
            for (int n = 0; n < 256; n++) if (int'(mem1[n]) !== ref_s[n]) bad++;
            checks++;
            if (bad !== 0 || lat !== 1025) begin
                failures++; $display("FAIL rand1 key=%h: bad=%0d lat=%0d want 0 1025", k1, bad, lat);
            end
        end
    endtask

    task automatic test_start_busy();
        int c, d0, bad;
        logic [23:0] ka, kb;
        ka = 24'($urandom);
        kb = ka ^ 24'h5A5A5A;
        compute_ref(256'(ka), 3);
        d0 = done_cnt3;
        @(negedge clk); start3 = 1'b1; key3 = ka;
        @(negedge clk); start3 = 1'b0;
        c = 1;
        while (done3 !== 1'b1 && c < 2000) begin
            @(negedge clk); c++;
            if (c == 5 || c == 600) begin start3 = 1'b1; key3 = kb; end
            else start3 = 1'b0;
        end
        start3 = 1'b0;
        repeat (5) @(negedge clk);
        bad = 0;
        for (int n = 0; n < 256; n++) if (int'(mem3[n]) !== ref_s[n]) bad++;
        checks++;
        if (c !== 1025 || done_cnt3 - d0 !== 1 || bad !== 0) begin
            failures++; $display("FAIL start_busy: lat=%0d dones=%0d bad=%0d want 1025 1 0", c, done_cnt3 - d0, bad);
        end
    endtask

    task automatic test_reset_mid();
        int d0, a0;
        @(negedge clk); start3 = 1'b1; key3 = 24'($urandom);
        @(negedge clk); start3 = 1'b0;
        repeat (699) @(negedge clk);
        d0 = done_cnt3;
        n_rst = 1'b0;
        #1;
        checks++;
        if ({busy3, done3, waddr3, wdata3, wen3, raddr3, ren3, swap3} !== 27'd0) begin
            failures++;
            $display("FAIL reset_mid: got %h want 0", {busy3, done3, waddr3, wdata3, wen3, raddr3, ren3, swap3});
        end
        @(negedge clk); n_rst = 1'b1;
        a0 = act3;
        repeat (1100) @(negedge clk);
        checks++;
        if (done_cnt3 - d0 !== 0 || act3 - a0 !== 0) begin
            failures++; $display("FAIL reset_mid_quiet: dones=%0d activity=%0d want 0 0", done_cnt3 - d0, act3 - a0);
        end
    endtask

    task automatic test_back_to_back();
        int c, c2, bad;
        logic b1026;
        logic [23:0] kk;
        kk = 24'($urandom);
        compute_ref(256'(kk), 3);
        @(negedge clk); start3 = 1'b1; key3 = kk;
        @(negedge clk);
        c = 1;
        while (done3 !== 1'b1 && c < 2000) begin @(negedge clk); c++; end
        @(negedge clk); b1026 = busy3;
        c2 = c + 1;
        while (done3 !== 1'b1 && c2 < 4000) begin @(negedge clk); c2++; end
        start3 = 1'b0;
        repeat (3) @(negedge clk);
        bad = 0;
        for (int n = 0; n < 256; n++) if (int'(mem3[n]) !== ref_s[n]) bad++;
        checks++;
        if (c !== 1025 || c2 !== 2051 || b1026 !== 1'b0 || bad !== 0 || busy3 !== 1'b0) begin
            failures++; $display("FAIL back_to_back: d1=%0d d2=%0d busy_idle=%b bad=%0d want 1025 2051 0 0",
                                 c, c2, b1026, bad);
        end
        checks++;
        if (excl3 !== 0) begin failures++; $display("FAIL exclusive_ctrl: violations=%0d want 0", excl3); end
    endtask

`ifdef RC4_KSA_ABORT_EN
    task automatic test_abort();
        int d0, a0, lat, bad;
        logic [23:0] kk;
        d0 = done_cnt3;
        @(negedge clk); start3 = 1'b1; key3 = 24'($urandom);
        @(negedge clk); start3 = 1'b0;
        repeat (299) @(negedge clk);
        abort3 = 1'b1;
        @(negedge clk); abort3 = 1'b0;
        checks++;
        if (busy3 !== 1'b0 || {wen3, ren3, swap3, done3} !== 4'd0) begin
            failures++; $display("FAIL abort_idle: busy=%b ctrl=%b want 0 0000", busy3, {wen3, ren3, swap3, done3});
        end
        a0 = act3;
        repeat (1100) @(negedge clk);
        checks++;
        if (done_cnt3 - d0 !== 0 || act3 - a0 !== 0) begin
            failures++; $display("FAIL abort_quiet: dones=%0d activity=%0d want 0 0", done_cnt3 - d0, act3 - a0);
        end
        kk = 24'($urandom);
        compute_ref(256'(kk), 3);
        do_run3(kk, lat);
        bad = 0;
        for (int n = 0; n < 256; n++) if (int'(mem3[n]) !== ref_s[n]) bad++;
        checks++;
        if (lat !== 1025 || bad !== 0) begin
            failures++; $display("FAIL abort_rerun: lat=%0d bad=%0d want 1025 0", lat, bad);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_identity_key();
        test_zero_key();
        test_key_len1();
        test_random();
        test_start_busy();
        test_reset_mid();
        test_back_to_back();
`ifdef RC4_KSA_ABORT_EN
        test_abort();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rc4_ksa.md
Name: rc4_ksa

Overview:
- RC4 key-scheduling controller that sits directly upstream of the sarr 256x8 state array and drives all of its control ports.
- On start it performs two passes over sarr:
  - identity fill, S[i]=i;
  - KSA permutation, j = j + S[i] + key[i mod KEY_LEN], then swap S[i] and S[j].
- When the array holds the keyed permutation it pulses done_o; the PRGA stage takes over from there.

Parameters:
- KEY_LEN, 3, key length in bytes (1..32).
- Key byte 0 is key_i[8*KEY_LEN-1 -: 8], i.e. MSB-first.

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous active-low reset.
- start_i  in  1  begin scheduling; sampled only in IDLE.
- key_i  in  8*KEY_LEN  key; latched on accepted start.
- busy_o  out  1  high from the cycle after start is accepted through the DONE state.
- done_o  out  1  one-cycle completion pulse.
- waddr_o  out  8  to sarr waddr_i.
- wdata_o  out  8  to sarr wdata_i.
- wenable_o  out  1  to sarr wenable_i.
- raddr_o  out  8  to sarr raddr_i.
- renable_o  out  1  to sarr renable_i.
- swap_o  out  1  to sarr swap_i; exchanges S[raddr] and S[waddr] in one cycle.
- rdata_i  in  8  from sarr rdata_o; valid the cycle after renable_o is sampled high.

Behaviour:
- Reset (n_rst low, any time, including mid-operation):
  - state IDLE; i, j, k and the key register cleared;
  - all outputs 0.
- After reset the array contents are undefined until a new start; no partial result is flagged.
- State register and counters are flops. Outputs are a Moore decode of state plus counters. In every state, any sarr control not listed below is 0.
- IDLE: start_i=1 latches key_i, clears i, j, k, goes to INIT.
- INIT (256 cycles):
  - wenable_o=1, waddr_o=i, wdata_o=i;
  - i increments each cycle;
  - at i==255: i<=0, j<=0, k<=0, go to READ_I.
- READ_I: renable_o=1, raddr_o=i; go to CALC_J.
- CALC_J:
  - j <= (j + rdata_i + keybyte[k]) mod 256, 8-bit wrapping add, carries discarded;
  - go to SWAP.
- SWAP:
  - swap_o=1, raddr_o=i, waddr_o=j (updated j);
  - i==j is legal; sarr leaves the array unchanged;
  - if i==255 go to DONE; else i++, go to READ_I;
  - k increments, wrapping to 0 after KEY_LEN-1 (independent of i wrap).
- DONE: done_o=1 for exactly one cycle; go to IDLE.
- Latency: start sampled at edge 0, so INIT covers cycles 1..256 and KSA covers cycles 257..1024 (3 cycles per i). done_o is high in cycle 1025.
- start_i while not IDLE is ignored, with no queueing. key_i changes after acceptance have no effect.
- start_i held high continuously: a new run begins in the cycle after DONE returns to IDLE.
- wenable_o, renable_o and swap_o are never asserted in the same cycle.

Optional Feature:
- Macro RC4_KSA_ABORT_EN.
- Defined:
  - adds input abort_i (1 bit);
  - abort_i=1 in any non-IDLE state forces IDLE at the next edge;
  - all sarr controls drop that cycle; done_o is not pulsed; busy_o falls;
  - abort_i is ignored in IDLE;
  - abort_i and start_i both high in IDLE: start wins.
- Undefined: no abort_i port; a run always completes to DONE.

Test Plan:
- Reset then idle: n_rst low mid-cycle -> all outputs 0 immediately (async). start_i=0 for 10 cycles -> no sarr enable asserted.
- Identity fill, key 0x010203: INIT writes addr=data=0..255 on consecutive cycles. Then:
  - first swap (i=0, j=1), so S[0]=1, S[1]=0;
  - second swap (i=1, j=3);
  - done_o exactly 1025 cycles after start; all checked against a reference model of sarr.
- Zero key, 0x000000: swaps (0,0), (1,1), (2,3) in order. Final array matches the software RC4 KSA for a 3-byte zero key.
- Wrap and KEY_LEN: KEY_LEN=1, key 0xFF. j sequence wraps mod 256 (i=0 gives j=0xFF). Final S matches the software model.
- start during busy: pulse start_i at cycles 5 and 600 with a different key_i -> single done_o; result reflects the first key. n_rst pulsed at cycle 700 -> IDLE, no done_o.
- With RC4_KSA_ABORT_EN: abort_i at cycle 300 -> next cycle IDLE, busy_o=0, no done_o. A following start completes normally in 1025 cycles.
